// File: rtl/m_dmem_ctrl_if.sv
// Request/response bus between a load-store unit (master) and m_dmem_ctrl (slave).
interface m_dmem_ctrl_if;
  logic        w_req_valid;
  logic        w_req_ready;
  logic        w_req_we;
  logic [2:0]  w_req_funct3;
  logic [31:0] w_req_addr;
  logic [31:0] w_req_wdata;
  logic        w_rsp_valid;
  logic        w_rsp_ready;
  logic [31:0] w_rsp_rdata;
  logic        w_rsp_fault;
  logic        w_busy;

  modport master (
    output w_req_valid, w_req_we, w_req_funct3, w_req_addr, w_req_wdata, w_rsp_ready,
    input  w_req_ready, w_rsp_valid, w_rsp_rdata, w_rsp_fault, w_busy
  );

  modport slave (
    input  w_req_valid, w_req_we, w_req_funct3, w_req_addr, w_req_wdata, w_rsp_ready,
    output w_req_ready, w_rsp_valid, w_rsp_rdata, w_rsp_fault, w_busy
  );
endinterface

// File: rtl/m_dmem_ctrl.sv
// Single-port data memory controller with RISC-V byte/half/word access and fixed wait states.
// Define DMEM_FAULT_CHECK_EN to fault misaligned, out-of-range and undefined-size requests.
module m_dmem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic          w_clk,
  input  logic          w_rst_n,
  m_dmem_ctrl_if.slave  bus
);
  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W}       size_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;
  logic        access;

  logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

  logic          acc_we;
  logic [2:0]    acc_f3;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  size_e         acc_size;
  logic [AW+1:0] acc_addr_al;
  logic [AW-1:0] acc_idx;
  logic [1:0]    acc_lane;
  logic [3:0]    acc_be;
  logic [31:0]   acc_wword;
  logic [31:0]   rd_word;
  logic [31:0]   rd_shift;
  logic [31:0]   load_data;
  logic          acc_fault;

  // With zero wait states the access happens on the accept edge, so the live request is used.
  always_comb begin
    if (state_q == S_IDLE) begin
      acc_we    = bus.w_req_we;
      acc_f3    = bus.w_req_funct3;
      acc_addr  = bus.w_req_addr;
      acc_wdata = bus.w_req_wdata;
    end else begin
      acc_we    = we_q;
      acc_f3    = funct3_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
  end

  always_comb begin
    case (acc_f3[1:0])
      2'b00:   acc_size = SZ_B;
      2'b01:   acc_size = SZ_H;
      default: acc_size = SZ_W;
    endcase

    acc_addr_al = acc_addr[AW+1:0];
    case (acc_size)
      SZ_H:    acc_addr_al[0]   = 1'b0;
      SZ_W:    acc_addr_al[1:0] = 2'b00;
      default: ;
    endcase
    acc_idx  = acc_addr_al[AW+1:2];
    acc_lane = acc_addr_al[1:0];

    case (acc_size)
      SZ_B:    acc_be = 4'b0001 << acc_lane;
      SZ_H:    acc_be = 4'b0011 << acc_lane;
      default: acc_be = 4'b1111;
    endcase
    acc_wword = acc_wdata << {acc_lane, 3'b000};

    rd_word  = mem[acc_idx];
    rd_shift = rd_word >> {acc_lane, 3'b000};
    case (acc_f3)
      3'b000:  load_data = {{24{rd_shift[7]}},  rd_shift[7:0]};
      3'b001:  load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  load_data = {24'b0, rd_shift[7:0]};
      3'b101:  load_data = {16'b0, rd_shift[15:0]};
      default: load_data = rd_shift;
    endcase
  end

`ifdef DMEM_FAULT_CHECK_EN
  always_comb begin
    acc_fault = 1'b0;
    if (acc_f3 inside {3'b011, 3'b110, 3'b111})            acc_fault = 1'b1;
    if (acc_we && (acc_f3 inside {3'b100, 3'b101}))        acc_fault = 1'b1;
    if ((acc_size == SZ_H) && acc_addr[0])                 acc_fault = 1'b1;
    if ((acc_size == SZ_W) && (acc_addr[1:0] != 2'b00))    acc_fault = 1'b1;
    if (acc_addr[31:AW+2] != '0)                           acc_fault = 1'b1;
  end
`else
  // Upper address bits are dropped so the word index wraps modulo DEPTH_WORDS.
  logic unused_addr_hi;
  assign unused_addr_hi = ^acc_addr[31:AW+2];
  assign acc_fault      = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    fault_d  = fault_q;
    access   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.w_req_valid) begin
          we_d     = bus.w_req_we;
          funct3_d = bus.w_req_funct3;
          addr_d   = bus.w_req_addr;
          wdata_d  = bus.w_req_wdata;
          if (WAIT_STATES == 0) begin
            state_d = S_RESP;
            access  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          access  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (bus.w_rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (access) begin
      fault_d = acc_fault;
      rdata_d = (acc_we || acc_fault) ? 32'd0 : load_data;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      fault_q  <= fault_d;
    end
  end

  // NOTE: the storage array has no reset; its contents deliberately survive w_rst_n.
  always_ff @(posedge w_clk) begin
    if (access && acc_we && !acc_fault) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_be[b]) mem[acc_idx][8*b +: 8] <= acc_wword[8*b +: 8];
      end
    end
  end

  assign bus.w_req_ready = (state_q == S_IDLE);
  assign bus.w_busy      = (state_q != S_IDLE);
  assign bus.w_rsp_valid = (state_q == S_RESP);
  assign bus.w_rsp_rdata = rdata_q;
  assign bus.w_rsp_fault = fault_q;
endmodule

// File: tb/tb_m_dmem_ctrl.sv
// Bench for m_dmem_ctrl: three instances (0, 1 and 3 wait states) driven by directed vectors,
// hand-written reset/back-pressure sequences and random traffic against a byte-array model.
module tb_m_dmem_ctrl;
  localparam int DEPTH = 64;
  localparam int BYTES = 4 * DEPTH;

  logic       clk = 1'b0;
  logic [2:0] rst_n = 3'b111;
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk = ~clk;

  m_dmem_ctrl_if if0 ();
  m_dmem_ctrl_if if1 ();
  m_dmem_ctrl_if if3 ();

  m_dmem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_ws0 (.w_clk(clk), .w_rst_n(rst_n[0]), .bus(if0.slave));
  m_dmem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(1)) u_ws1 (.w_clk(clk), .w_rst_n(rst_n[1]), .bus(if1.slave));
  m_dmem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) u_ws3 (.w_clk(clk), .w_rst_n(rst_n[2]), .bus(if3.slave));

  // Byte-addressed picture of each instance's memory.
  logic [7:0] mdl [3][BYTES];

  typedef struct packed {
    logic        rdy;
    logic        vld;
    logic        flt;
    logic        busy;
    logic [31:0] rdata;
  } outs_t;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_flt;
  } vec_t;

  vec_t vecs[$];

  function automatic int ws_of(input int s);
    case (s)
      0:       return 0;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  function automatic outs_t sample(input int s);
    outs_t o;
    case (s)
      0:       o = '{if0.w_req_ready, if0.w_rsp_valid, if0.w_rsp_fault, if0.w_busy, if0.w_rsp_rdata};
      1:       o = '{if1.w_req_ready, if1.w_rsp_valid, if1.w_rsp_fault, if1.w_busy, if1.w_rsp_rdata};
      default: o = '{if3.w_req_ready, if3.w_rsp_valid, if3.w_rsp_fault, if3.w_busy, if3.w_rsp_rdata};
    endcase
    return o;
  endfunction

  task automatic drive(input int s, input logic v, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    case (s)
      0: begin if0.w_req_valid = v; if0.w_req_we = we; if0.w_req_funct3 = f3; if0.w_req_addr = a; if0.w_req_wdata = d; end
      1: begin if1.w_req_valid = v; if1.w_req_we = we; if1.w_req_funct3 = f3; if1.w_req_addr = a; if1.w_req_wdata = d; end
      default: begin if3.w_req_valid = v; if3.w_req_we = we; if3.w_req_funct3 = f3; if3.w_req_addr = a; if3.w_req_wdata = d; end
    endcase
  endtask

  task automatic set_rready(input int s, input logic r);
    case (s)
      0:       if0.w_rsp_ready = r;
      1:       if1.w_rsp_ready = r;
      default: if3.w_rsp_ready = r;
    endcase
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference behaviour: sizes, alignment, range and extension straight from the access rules.
  function automatic void model(input int s, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic [31:0] rd, output logic flt);
    int          size;
    logic [31:0] a;
    logic [31:0] v;
    int          idx;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      default:    size = 4;
    endcase
    rd  = 32'd0;
    flt = 1'b0;
`ifdef DMEM_FAULT_CHECK_EN
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) flt = 1'b1;
    if (we && (f3 == 3'd4 || f3 == 3'd5))       flt = 1'b1;
    if (addr % size != 0)                        flt = 1'b1;
    if (addr >= BYTES)                           flt = 1'b1;
    a = addr;
`else
    a = addr - addr % size;
`endif
    if (flt) return;
    v = 32'd0;
    for (int i = 0; i < size; i++) begin
      idx = int'((a + i) % BYTES);
      if (we) mdl[s][idx] = wdata[8*i +: 8];
      else    v = v | (32'(mdl[s][idx]) << (8 * i));
    end
    if (!we) begin
      if (size < 4 && (f3 == 3'd0 || f3 == 3'd1) && v[8*size-1]) v = v | ~((32'd1 << (8 * size)) - 32'd1);
      rd = v;
    end
  endfunction

  // One complete transaction with optional response back-pressure; checks timing and handshake.
  task automatic txn(input int s, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input int hold, output logic [31:0] rd, output logic flt);
    outs_t o;
    int    lat;
    string tag;
    tag = $sformatf("ws%0d %s a=%0h f3=%0d", ws_of(s), we ? "st" : "ld", addr, f3);
    @(negedge clk);
    o = sample(s);
    check({tag, " req_ready"}, 32'(o.rdy), 32'd1);
    drive(s, 1'b1, we, f3, addr, wdata);
    @(posedge clk);
    @(negedge clk);
    drive(s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom);
    lat = 1;
    o   = sample(s);
    while (!o.vld && lat < 40) begin
      @(negedge clk);
      lat++;
      o = sample(s);
    end
    check({tag, " latency"}, 32'(lat), 32'(ws_of(s) + 1));
    rd  = o.rdata;
    flt = o.flt;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      o = sample(s);
      check({tag, " hold valid"}, 32'(o.vld), 32'd1);
      check({tag, " hold rdata"}, o.rdata, rd);
      check({tag, " hold fault"}, 32'(o.flt), 32'(flt));
      check({tag, " hold req_ready"}, 32'(o.rdy), 32'd0);
    end
    set_rready(s, 1'b1);
    @(negedge clk);
    set_rready(s, 1'b0);
    o = sample(s);
    check({tag, " done valid"}, 32'(o.vld), 32'd0);
    check({tag, " done busy"}, 32'(o.busy), 32'd0);
    check({tag, " done req_ready"}, 32'(o.rdy), 32'd1);
    drive(s, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
  endtask

  task automatic add(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rd, input logic exp_flt);
    vec_t v;
    v = '{we, f3, addr, wdata, exp_rd, exp_flt};
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] rd, exp_rd;
    logic        flt, exp_flt;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr, wdata;
    logic [2:0]  st_codes [6];
    outs_t       o;

    st_codes = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
    for (int s = 0; s < 3; s++) begin
      for (int b = 0; b < BYTES; b++) mdl[s][b] = 8'h00;
      drive(s, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
      set_rready(s, 1'b0);
    end

    #1 rst_n = 3'b000;
    #2;
    for (int s = 0; s < 3; s++) begin
      o = sample(s);
      check($sformatf("ws%0d reset req_ready", ws_of(s)), 32'(o.rdy), 32'd1);
      check($sformatf("ws%0d reset rsp_valid", ws_of(s)), 32'(o.vld), 32'd0);
      check($sformatf("ws%0d reset fault", ws_of(s)), 32'(o.flt), 32'd0);
      check($sformatf("ws%0d reset busy", ws_of(s)), 32'(o.busy), 32'd0);
      check($sformatf("ws%0d reset rdata", ws_of(s)), o.rdata, 32'd0);
    end
    repeat (2) @(negedge clk);
    rst_n = 3'b111;

    add(1'b1, 3'd2, 32'd8,  32'hDEADBEEF, 32'h00000000, 1'b0);
    add(1'b0, 3'd2, 32'd8,  32'h0,        32'hDEADBEEF, 1'b0);
    add(1'b1, 3'd2, 32'd8,  32'h11223344, 32'h00000000, 1'b0);
    add(1'b1, 3'd0, 32'd9,  32'h000000F0, 32'h00000000, 1'b0);
    add(1'b0, 3'd0, 32'd9,  32'h0,        32'hFFFFFFF0, 1'b0);
    add(1'b0, 3'd4, 32'd9,  32'h0,        32'h000000F0, 1'b0);
    add(1'b0, 3'd2, 32'd8,  32'h0,        32'h1122F044, 1'b0);
    add(1'b0, 3'd1, 32'd8,  32'h0,        32'hFFFFF044, 1'b0);
    add(1'b0, 3'd5, 32'd10, 32'h0,        32'h00001122, 1'b0);
    add(1'b1, 3'd1, 32'd14, 32'hABCD8001, 32'h00000000, 1'b0);
    add(1'b0, 3'd2, 32'd12, 32'h0,        32'h80010000, 1'b0);
    add(1'b0, 3'd1, 32'd14, 32'h0,        32'hFFFF8001, 1'b0);
`ifdef DMEM_FAULT_CHECK_EN
    add(1'b1, 3'd1, 32'd3,   32'h00007777, 32'h00000000, 1'b1);
    add(1'b0, 3'd2, 32'd256, 32'h0,        32'h00000000, 1'b1);
    add(1'b0, 3'd2, 32'd0,   32'h0,        32'h00000000, 1'b0);
    add(1'b1, 3'd4, 32'd8,   32'h000000AA, 32'h00000000, 1'b1);
    add(1'b0, 3'd6, 32'd8,   32'h0,        32'h00000000, 1'b1);
    add(1'b0, 3'd2, 32'd8,   32'h0,        32'h1122F044, 1'b0);
`else
    add(1'b1, 3'd2, 32'd0,         32'hCAFEF00D, 32'h00000000, 1'b0);
    add(1'b0, 3'd2, 32'd258,       32'h0,        32'hCAFEF00D, 1'b0);
    add(1'b1, 3'd1, 32'd3,         32'h00007777, 32'h00000000, 1'b0);
    add(1'b0, 3'd2, 32'd0,         32'h0,        32'h7777F00D, 1'b0);
    add(1'b0, 3'd5, 32'd3,         32'h0,        32'h00007777, 1'b0);
    add(1'b0, 3'd2, 32'h40000008,  32'h0,        32'h1122F044, 1'b0);
`endif
    foreach (vecs[i]) begin
      model(1, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, exp_rd, exp_flt);
      txn(1, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, 0, rd, flt);
      check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d fault", i), 32'(flt), 32'(vecs[i].exp_flt));
    end

    // Response back-pressure: three cycles with rsp_ready low.
    model(1, 1'b0, 3'd2, 32'd8, 32'd0, exp_rd, exp_flt);
    txn(1, 1'b0, 3'd2, 32'd8, 32'd0, 3, rd, flt);
    check("backpressure rdata", rd, 32'h1122F044);

    // Zero wait states: response the cycle after accept.
    model(0, 1'b1, 3'd2, 32'd8, 32'hDEADBEEF, exp_rd, exp_flt);
    txn(0, 1'b1, 3'd2, 32'd8, 32'hDEADBEEF, 0, rd, flt);
    model(0, 1'b0, 3'd2, 32'd8, 32'd0, exp_rd, exp_flt);
    txn(0, 1'b0, 3'd2, 32'd8, 32'd0, 1, rd, flt);
    check("ws0 lw rdata", rd, 32'hDEADBEEF);

    // Reset during WAIT must abort the pending store.
    model(2, 1'b1, 3'd2, 32'd4, 32'h12345678, exp_rd, exp_flt);
    txn(2, 1'b1, 3'd2, 32'd4, 32'h12345678, 0, rd, flt);
    model(2, 1'b0, 3'd2, 32'd4, 32'd0, exp_rd, exp_flt);
    txn(2, 1'b0, 3'd2, 32'd4, 32'd0, 0, rd, flt);
    check("ws3 lw before reset", rd, 32'h12345678);
    @(negedge clk);
    drive(2, 1'b1, 1'b1, 3'd2, 32'd4, 32'h00000005);
    @(posedge clk);
    @(negedge clk);
    drive(2, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    o = sample(2);
    check("ws3 busy in wait", 32'(o.busy), 32'd1);
    @(posedge clk);
    #2 rst_n[2] = 1'b0;
    #1 o = sample(2);
    check("ws3 mid-reset req_ready", 32'(o.rdy), 32'd1);
    check("ws3 mid-reset rsp_valid", 32'(o.vld), 32'd0);
    check("ws3 mid-reset rdata", o.rdata, 32'd0);
    check("ws3 mid-reset fault", 32'(o.flt), 32'd0);
    check("ws3 mid-reset busy", 32'(o.busy), 32'd0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n[2] = 1'b1;
    txn(2, 1'b0, 3'd2, 32'd4, 32'd0, 0, rd, flt);
    check("ws3 lw after reset", rd, 32'h12345678);
    check("ws3 lw after reset fault", 32'(flt), 32'd0);

    // Random traffic on every instance against the byte-array model.
    for (int s = 0; s < 3; s++) begin
      for (int n = 0; n < 40; n++) begin
        we = 1'($urandom_range(0, 1));
`ifdef DMEM_FAULT_CHECK_EN
        f3 = 3'($urandom_range(0, 7));
`else
        f3 = we ? st_codes[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
`endif
        addr  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, BYTES + 40));
        wdata = $urandom;
        model(s, we, f3, addr, wdata, exp_rd, exp_flt);
        txn(s, we, f3, addr, wdata, $urandom_range(0, 2), rd, flt);
        check($sformatf("rand ws%0d #%0d rdata", ws_of(s), n), rd, exp_rd);
        check($sformatf("rand ws%0d #%0d fault", ws_of(s), n), 32'(flt), 32'(exp_flt));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/m_dmem_ctrl.md
M_DMEM_CTRL -- requirements
Module: m_dmem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64, number of 32-bit words stored (power of two, >=2).
REQ-002 SHALL have parameter WAIT_STATES, default 1, extra cycles between request accept and access (0..15).
REQ-003 SHALL have port w_clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port w_rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port w_req_valid  input  1  request present.
REQ-006 SHALL have port w_req_ready  output  1  controller can accept a request.
REQ-007 SHALL have port w_req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port w_req_funct3  input  3  RISC-V size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 SHALL have port w_req_addr  input  32  byte address.
REQ-010 SHALL have port w_req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port w_rsp_valid  output  1  response present.
REQ-012 SHALL have port w_rsp_ready  input  1  consumer accepts response.
REQ-013 SHALL have port w_rsp_rdata  output  32  load result, extended per funct3; 0 for stores and faults.
REQ-014 SHALL have port w_rsp_fault  output  1  request was not performed.
REQ-015 SHALL have port w_busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; w_req_ready = 1 only in IDLE.
REQ-017 SHALL accept a request on a rising edge with w_req_valid & w_req_ready, latching we, funct3, addr, wdata.
REQ-018 SHALL, on accept, go to WAIT with counter = WAIT_STATES-1 when WAIT_STATES>0, else directly to RESP.
REQ-019 SHALL decrement the counter each WAIT cycle and go to RESP on the edge where it is 0.
REQ-020 SHALL perform the memory access (store commit or load capture) on the edge entering RESP; rsp_valid rises WAIT_STATES+1 cycles after accept.
REQ-021 SHALL hold w_rsp_valid, w_rsp_rdata, w_rsp_fault stable in RESP until w_rsp_ready = 1, then return to IDLE on that edge.
REQ-022 SHALL NOT accept a new request in the same cycle a response completes (one cycle of IDLE between transactions).
REQ-023 SHALL index words by addr[log2(DEPTH_WORDS)+1:2] and select byte lanes by addr[1:0], little-endian.
REQ-024 SHALL store only the addressed lanes: SB writes 1 byte, SH 2 bytes, SW 4 bytes; other lanes unchanged.
REQ-025 SHALL sign-extend B/H loads, zero-extend BU/HU loads, return W unchanged.
REQ-026 SHALL ignore w_req_* inputs outside the accept edge.
REQ-027 SHALL return w_rsp_rdata = 0 for stores.

Reset
REQ-028 SHALL on w_rst_n low immediately force IDLE, counter 0, w_req_ready 1, w_rsp_valid 0, w_rsp_rdata 0, w_rsp_fault 0, w_busy 0.
REQ-029 SHALL NOT commit a store whose RESP entry edge had not occurred before reset asserted.
REQ-030 SHALL NOT clear memory contents on reset; contents initialise to 0 at time zero only.

Configuration
REQ-031 SHALL, with DMEM_FAULT_CHECK_EN defined, fault (no write, rdata 0, fault 1) on misalignment (H/HU addr[0]=1, W addr[1:0]!=0), addr >= 4*DEPTH_WORDS, or undefined funct3 (011/110/111; also 100/101 for stores).
REQ-032 SHALL, without DMEM_FAULT_CHECK_EN, tie w_rsp_fault to 0, force-align the address to the access size, wrap the word index modulo DEPTH_WORDS, and treat undefined funct3 as W.

Verification
REQ-033 SHALL cover: WAIT_STATES=1, SW addr 8 data 0xDEADBEEF, then LW addr 8 -> rsp_valid 2 cycles after each accept, rdata 0xDEADBEEF.
REQ-034 SHALL cover: SB addr 9 data 0x000000F0 over 0x11223344, then LB addr 9 -> rdata 0xFFFFFFF0; LBU -> 0x000000F0; LW addr 8 -> 0x1122F044.
REQ-035 SHALL cover: rsp_ready held 0 for 3 cycles in RESP -> rsp_valid/rdata stable, req_ready 0 throughout, IDLE one cycle after rsp_ready=1.
REQ-036 SHALL cover: with DMEM_FAULT_CHECK_EN, SH addr 3 and LW addr 256 (DEPTH 64) -> fault 1, rdata 0, memory unchanged; without it, LW addr 258 returns word 0.
REQ-037 SHALL cover: WAIT_STATES=3, w_rst_n low during WAIT after SW addr 4 data 0x5 -> outputs at reset values, subsequent LW addr 4 returns prior contents.
REQ-038 SHALL cover: WAIT_STATES=0 -> rsp_valid asserted the cycle after accept.
